// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
// The load-writeback entry pairs a destination index with its data.
package regfile_sched_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bundle of writeback, load-issue, decode-hazard and register-file signals.
// The scheduler takes the slave view; upstream and the register file take the master view.
interface regfile_write_scheduler_if #(
    parameter int XLEN = regfile_sched_pkg::XLEN
);
    logic            alu_wb_valid;
    logic [4:0]      alu_wb_dst;
    logic [XLEN-1:0] alu_wb_data;
    logic            ld_issue_valid;
    logic [4:0]      ld_issue_dst;
    logic            ld_issue_ready;
    logic            ld_wb_valid;
    logic [4:0]      ld_wb_dst;
    logic [XLEN-1:0] ld_wb_data;
    logic            ld_wb_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            hazard;
    logic            init_done;
    logic [4:0]      rf_dst;
    logic [XLEN-1:0] rf_dataIn;
    logic            rf_writeEnable;

    modport slave (
        input  alu_wb_valid, alu_wb_dst, alu_wb_data,
        input  ld_issue_valid, ld_issue_dst,
        input  ld_wb_valid, ld_wb_dst, ld_wb_data,
        input  rs1, rs2,
        output ld_issue_ready, ld_wb_ready, hazard, init_done,
        output rf_dst, rf_dataIn, rf_writeEnable
    );

    modport master (
        output alu_wb_valid, alu_wb_dst, alu_wb_data,
        output ld_issue_valid, ld_issue_dst,
        output ld_wb_valid, ld_wb_dst, ld_wb_data,
        output rs1, rs2,
        input  ld_issue_ready, ld_wb_ready, hazard, init_done,
        input  rf_dst, rf_dataIn, rf_writeEnable
    );
endinterface

// File: rtl/regfile_wb_fifo.sv
// Small synchronous FIFO holding load results that lost write-port arbitration.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module regfile_wb_fifo
    import regfile_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was pushed.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register file write port: post-reset clear of x1..x31, then ALU-first
// arbitration against buffered load returns, with a per-register load scoreboard.
module regfile_write_scheduler
    import regfile_sched_pkg::*;
#(
    parameter int XLEN      = regfile_sched_pkg::XLEN,
    parameter int LWB_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    regfile_write_scheduler_if.slave  bus
);
    state_e              state_q, state_d;
    logic [4:0]          clr_idx_q, clr_idx_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic      run, clearing;
    logic      alu_take, pop, push, issue_fire;
    logic      fifo_full, fifo_empty;
    logic      wb_ready, issue_ready;
    wb_entry_t head, push_entry;

    // Outputs are forced idle while reset is held, even before the state register reloads.
    assign run      = (state_q == S_RUN) && !reset;
    assign clearing = (state_q == S_CLEAR) && !reset;

    assign alu_take    = run && bus.alu_wb_valid && (bus.alu_wb_dst != 5'd0);
    assign pop         = run && !alu_take && !fifo_empty;
    assign wb_ready    = run && (!fifo_full || pop);
    assign push        = bus.ld_wb_valid && wb_ready && (bus.ld_wb_dst != 5'd0);
    assign issue_ready = run && !busy_q[bus.ld_issue_dst];
    assign issue_fire  = bus.ld_issue_valid && issue_ready && (bus.ld_issue_dst != 5'd0);

    assign push_entry.dst  = bus.ld_wb_dst;
    assign push_entry.data = bus.ld_wb_data;

    assign bus.ld_wb_ready    = wb_ready;
    assign bus.ld_issue_ready = issue_ready;
    assign bus.init_done      = run;
    assign bus.hazard         = !run || busy_q[bus.rs1] || busy_q[bus.rs2];

    regfile_wb_fifo #(
        .DEPTH (LWB_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_comb begin
        bus.rf_writeEnable = 1'b0;
        bus.rf_dst         = 5'd0;
        bus.rf_dataIn      = {XLEN{1'b0}};
        if (clearing) begin
            bus.rf_writeEnable = 1'b1;
            bus.rf_dst         = clr_idx_q;
        end else if (alu_take) begin
            bus.rf_writeEnable = 1'b1;
            bus.rf_dst         = bus.alu_wb_dst;
            bus.rf_dataIn      = bus.alu_wb_data;
        end else if (pop) begin
            bus.rf_writeEnable = 1'b1;
            bus.rf_dst         = head.dst;
            bus.rf_dataIn      = head.data;
        end
    end

    // One outstanding load per register means set and clear never target the same bit.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        if (state_q == S_CLEAR) begin
            clr_idx_d = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) state_d = S_RUN;
        end
        if (pop)        busy_d[head.dst]         = 1'b0;
        if (issue_fire) busy_d[bus.ld_issue_dst] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= 5'd1;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // Decode stalls should make an ALU write to a register with a load in flight impossible.
    alu_busy_write_a: assert property (
        @(posedge clk) disable iff (reset) !(alu_take && busy_q[bus.alu_wb_dst])
    );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench: clear sequence, a cycle-by-cycle vector table for arbitration,
// scoreboard, x0 and buffer-full behaviour, then a mid-operation reset.
module tb_regfile_write_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_write_scheduler_if #(.XLEN(32)) bus ();

    regfile_write_scheduler #(
        .XLEN      (32),
        .LWB_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ad;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  ld;
        logic [31:0] ldat;
        logic        iv;
        logic [4:0]  id;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ewe;
        logic [4:0]  edst;
        logic [31:0] edat;
        logic        ehz;
        logic        eir;
        logic        ewr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ad, input logic [31:0] adat,
        input logic lv, input logic [4:0] ld, input logic [31:0] ldat,
        input logic iv, input logic [4:0] id,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic ewe, input logic [4:0] edst, input logic [31:0] edat,
        input logic ehz, input logic eir, input logic ewr);
        vec_t v;
        v.av = av;   v.ad = ad;     v.adat = adat;
        v.lv = lv;   v.ld = ld;     v.ldat = ldat;
        v.iv = iv;   v.id = id;     v.r1 = r1;     v.r2 = r2;
        v.ewe = ewe; v.edst = edst; v.edat = edat;
        v.ehz = ehz; v.eir = eir;   v.ewr = ewr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.alu_wb_valid   = v.av;
        bus.alu_wb_dst     = v.ad;
        bus.alu_wb_data    = v.adat;
        bus.ld_wb_valid    = v.lv;
        bus.ld_wb_dst      = v.ld;
        bus.ld_wb_data     = v.ldat;
        bus.ld_issue_valid = v.iv;
        bus.ld_issue_dst   = v.id;
        bus.rs1            = v.r1;
        bus.rs2            = v.r2;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        chk($sformatf("vec%0d.we", idx), 32'(bus.rf_writeEnable), 32'(v.ewe));
        if (v.ewe) begin
            chk($sformatf("vec%0d.dst", idx), 32'(bus.rf_dst), 32'(v.edst));
            chk($sformatf("vec%0d.data", idx), bus.rf_dataIn, v.edat);
        end
        chk($sformatf("vec%0d.hazard", idx), 32'(bus.hazard), 32'(v.ehz));
        chk($sformatf("vec%0d.issue_rdy", idx), 32'(bus.ld_issue_ready), 32'(v.eir));
        chk($sformatf("vec%0d.wb_rdy", idx), 32'(bus.ld_wb_ready), 32'(v.ewr));
    endtask

    task automatic idleInputs();
        applyStimulus(mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 0,0,0));
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, ".we"}, 32'(bus.rf_writeEnable), 32'd0);
        chk({tag, ".init_done"}, 32'(bus.init_done), 32'd0);
        chk({tag, ".hazard"}, 32'(bus.hazard), 32'd1);
        chk({tag, ".issue_rdy"}, 32'(bus.ld_issue_ready), 32'd0);
        chk({tag, ".wb_rdy"}, 32'(bus.ld_wb_ready), 32'd0);
    endtask

    // Called at the negedge where reset has just dropped; leaves the bench in RUN at a negedge.
    task automatic runClear(input string tag);
        for (int k = 1; k <= 31; k++) begin
            #1;
            chk($sformatf("%s.clr%0d.we", tag, k), 32'(bus.rf_writeEnable), 32'd1);
            chk($sformatf("%s.clr%0d.dst", tag, k), 32'(bus.rf_dst), 32'(k));
            chk($sformatf("%s.clr%0d.data", tag, k), bus.rf_dataIn, 32'd0);
            chk($sformatf("%s.clr%0d.init", tag, k), 32'(bus.init_done), 32'd0);
            chk($sformatf("%s.clr%0d.hazard", tag, k), 32'(bus.hazard), 32'd1);
            @(negedge clk);
        end
        #1;
        chk({tag, ".init_done"}, 32'(bus.init_done), 32'd1);
        chk({tag, ".post_we"}, 32'(bus.rf_writeEnable), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Cycle-by-cycle vectors; outputs are for the cycle in which the row is applied.
        //                  av ad  adat          lv ld  ldat     iv id  r1  r2  we dst edat          hz ir wr
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  0, 0,  5,  0,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  1, 5,  5,  0,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(1, 3,  32'h11,       1, 5,  32'hAB, 0, 5,  5,  0,  1, 3,  32'h11,       1, 0, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  0, 5,  5,  0,  1, 5,  32'hAB,       1, 0, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  0, 5,  5,  0,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  1, 7,  0,  7,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  1, 7,  0,  7,  0, 0,  32'h0,        1, 0, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  0, 7,  0,  0,  0, 0,  32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 0,  32'h0,        1, 7,  32'h77, 0, 7,  0,  7,  0, 0,  32'h0,        1, 0, 1));
        vecs.push_back(mk(1, 0,  32'hFF,       0, 0,  32'h0,  0, 7,  0,  7,  1, 7,  32'h77,       1, 0, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  0, 7,  0,  7,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  1, 0,  0,  0,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(1, 0,  32'hFF,       0, 0,  32'h0,  0, 0,  0,  0,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        1, 0,  32'h55, 0, 0,  0,  0,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  0, 0,  0,  0,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(1, 31, 32'hDEADBEEF, 0, 0,  32'h0,  0, 0,  0,  0,  1, 31, 32'hDEADBEEF, 0, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  1, 12, 0,  0,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  1, 13, 0,  0,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  1, 14, 0,  0,  0, 0,  32'h0,        0, 1, 1));
        vecs.push_back(mk(1, 1,  32'h100,      1, 12, 32'hC0, 0, 0,  12, 0,  1, 1,  32'h100,      1, 1, 1));
        vecs.push_back(mk(1, 1,  32'h101,      1, 13, 32'hC1, 0, 0,  12, 0,  1, 1,  32'h101,      1, 1, 1));
        vecs.push_back(mk(1, 1,  32'h102,      1, 14, 32'hC2, 0, 0,  12, 0,  1, 1,  32'h102,      1, 1, 0));
        vecs.push_back(mk(1, 1,  32'h103,      1, 14, 32'hC2, 0, 0,  12, 0,  1, 1,  32'h103,      1, 1, 0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 14, 32'hC2, 0, 0,  12, 0,  1, 12, 32'hC0,       1, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  0, 0,  14, 0,  1, 13, 32'hC1,       1, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  0, 0,  14, 0,  1, 14, 32'hC2,       1, 1, 1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,  0, 0,  14, 13, 0, 0,  32'h0,        0, 1, 1));

        idleInputs();
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkResetOutputs("reset0");
        @(negedge clk);
        reset = 1'b0;
        runClear("clear0");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
        end

        // Every scoreboard bit should be clear now, including after the x0 issue.
        @(negedge clk);
        idleInputs();
        for (int r = 0; r < 32; r++) begin
            bus.rs1 = 5'(r);
            #1;
            chk($sformatf("busy_clear.x%0d", r), 32'(bus.hazard), 32'd0);
        end

        // Mid-run reset with two buffered loads and x9/x10 pending.
        @(negedge clk);
        applyStimulus(mk(0,0,0, 0,0,0, 1,9, 0,0, 0,0,0, 0,1,1));
        @(negedge clk);
        applyStimulus(mk(0,0,0, 0,0,0, 1,10, 0,0, 0,0,0, 0,1,1));
        @(negedge clk);
        applyStimulus(mk(1,1,32'h1, 1,9,32'h99, 0,0, 0,0, 0,0,0, 0,1,1));
        @(negedge clk);
        applyStimulus(mk(1,1,32'h2, 1,10,32'hAA, 0,0, 0,0, 0,0,0, 0,1,1));
        @(negedge clk);
        idleInputs();
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_dst   = 5'd2;
        bus.rs1          = 5'd9;
        #1;
        chk("prereset.wb_rdy", 32'(bus.ld_wb_ready), 32'd0);
        chk("prereset.hazard", 32'(bus.hazard), 32'd1);
        @(negedge clk);
        idleInputs();
        reset = 1'b1;
        #1;
        checkResetOutputs("reset1");
        @(negedge clk);
        #1;
        checkResetOutputs("reset1b");
        @(negedge clk);
        reset = 1'b0;
        runClear("clear1");
        bus.rs1          = 5'd9;
        bus.rs2          = 5'd10;
        bus.ld_issue_dst = 5'd9;
        #1;
        chk("postreset.we", 32'(bus.rf_writeEnable), 32'd0);
        chk("postreset.hazard", 32'(bus.hazard), 32'd0);
        chk("postreset.issue_rdy", 32'(bus.ld_issue_ready), 32'd1);
        chk("postreset.wb_rdy", 32'(bus.ld_wb_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("postreset.we2", 32'(bus.rf_writeEnable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
